// File: rtl/encoder_pkg.sv
// Shared definitions for the sequential 32-to-5 encoder.
//   DATA_W     : width of the request word
//   IDX_W      : width of an encoded index
//   state_t    : controller states (IDLE, EMIT)
//   single_bit : true when a word has exactly one bit set
package encoder_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Clearing the lowest set bit leaves zero only for a one-hot word.
  // This avoids a popcount adder tree.
  function automatic logic single_bit(input logic [DATA_W-1:0] w);
    return (w != '0) && ((w & (w - DATA_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_enc_32to5.sv
// Combinational priority encoder, 32-bit request to 5-bit index.
//   LSB_FIRST : 1 = report lowest set index, 0 = report highest set index
//   req       : input  [31:0] request word
//   idx       : output [4:0]  index of the winning set bit (0 when req==0)
module prio_enc_32to5
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [DATA_W-1:0] req,
  output logic [IDX_W-1:0]  idx
);

  generate
    if (LSB_FIRST) begin : g_lsb
      // Scan downward so the lowest set bit is the final assignment.
      always_comb begin
        idx = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
          if (req[i]) idx = IDX_W'(i);
        end
      end
    end else begin : g_msb
      // Scan upward so the highest set bit is the final assignment.
      always_comb begin
        idx = '0;
        for (int i = 0; i < DATA_W; i++) begin
          if (req[i]) idx = IDX_W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/encoder_32to5_seq.sv
// Sequential 32-to-5 encoder: captures a request word and emits the index
// of every set bit, one per accepted valid/ready handshake.
//   LSB_FIRST : 1 = lowest index first, 0 = highest index first
//   clk       : input, rising-edge clock
//   rst       : input, synchronous active-high reset
//   D         : input  [31:0] request word, sampled on an accepted load
//   load      : input, capture D (ignored while busy)
//   busy      : output, captured word still has unemitted bits
//   A         : output [4:0] current index, meaningful when valid
//   valid     : output, A is awaiting acceptance
//   ready     : input, consumer accepts A when valid && ready
//   last      : output, A is the final set bit of the word
//   zero      : output, one-cycle pulse after loading an all-zero word
module encoder_32to5_seq
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D,
  input  logic              load,
  output logic              busy,
  output logic [IDX_W-1:0]  A,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              zero
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] pending_reg, pending_next;
  logic              zero_reg, zero_next;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_last;

  prio_enc_32to5 #(
    .LSB_FIRST(LSB_FIRST)
  ) u_prio (
    .req(pending_reg),
    .idx(cur_idx)
  );

  assign cur_last = single_bit(pending_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      zero_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      zero_reg    <= zero_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    zero_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          if (D != '0) begin
            pending_next = D;
            state_next   = EMIT;
          end else begin
            zero_next = 1'b1;
          end
        end
      end
      EMIT: begin
        // Handshake retires exactly the bit being shown on A; without it
        // pending (and therefore A and last) holds.
        if (ready) begin
          pending_next = pending_reg & ~(ONE << cur_idx);
          if (cur_last) state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  assign valid = (state_reg == EMIT);
  assign busy  = valid;
  // pending is cleared whenever the controller is idle, so A and last
  // naturally read zero outside EMIT.
  assign A     = cur_idx;
  assign last  = cur_last;
  assign zero  = zero_reg;

endmodule
